adc_window_event_ctrl: RTL and testbench
========================================

// Module: adc_window_event_ctrl
// PURPOSE
//  Parametrised successor ADC threshold-event controller. Each of N channels compares the ADC sample stream against its own threshold.
//  Adds per-channel hysteresis, a persistence (debounce) filter, selectable rising/falling/both edge mode, sticky W1C interrupt
//  status, and saturating event counters. Sits between the ADC word-clock sample register and the interrupt/CSR fabric.
// PARAMETERS
//  N        10  number of threshold channels
//  DATA_W   10  unsigned sample/threshold width
//  PERSIST  2   consecutive valid samples a new level must hold before the state flips (>=1)
//  CNT_W    8   per-channel event counter width
// PORTS
//  adc_wclk       in   1         ADC word clock; sole clock domain
//  adc_wclk_rst   in   1         reset, synchronous, active-high
//  data_in        in   DATA_W    unsigned ADC sample
//  data_valid     in   1         data_in qualifier; logic advances only when high
//  thr_bus        in   N*DATA_W  ch i threshold at [i*DATA_W +: DATA_W]
//  hyst           in   DATA_W    hysteresis shared by all channels
//  mode_bus       in   2*N       ch i at [2i+:2]: 00 off, 01 rising, 10 falling, 11 both
//  event_en       in   N         enables status set / counter increment
//  event_mask     in   N         1 = status bit excluded from intr
//  intr_clr       in   N         W1C single-cycle clear of intr_status
//  above          out  N         filtered level state (1 = above window)
//  event_pulse    out  N         1-cycle pulse per qualified edge (independent of event_en)
//  intr_status    out  N         sticky status
//  intr           out  1         |(intr_status & ~event_mask), registered
//  evt_cnt_bus    out  N*CNT_W   ch i counter at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  Reset: every output, armed flag and persistence counter = 0; reset overrides all other inputs on the same edge.
//  Reset mid-persistence discards partial counts; the block re-arms.
//  Window per ch: hi = thr; lo = (thr > hyst) ? thr-hyst : 0.
//  Candidate level: if above=0, cand=1 when data_in>=hi; if above=1, cand=0 when data_in<lo; otherwise no candidate.
//  Arming: first data_valid after reset sets above[i] = (data_in >= thr) for all channels, directly.
//   Arming applies no persistence and raises no events; the armed flag then = 1.
//  Persistence (armed, data_valid=1):
//   - a sample carrying a candidate increments pcnt[i];
//   - a sample without a candidate clears pcnt[i];
//   - when the incremented value reaches PERSIST: above[i] toggles, pcnt[i] clears, edge detected on that edge.
//   data_valid=0 holds all state (pcnt not cleared).
//  Event: edge 0->1 qualifies if mode[0]; edge 1->0 qualifies if mode[1]; mode 00 still tracks above, with no events.
//  Latency: event_pulse, above, intr_status and evt_cnt are all registered, high/updated in the cycle after the edge
//   capturing the PERSIST-th sample. intr follows one cycle later.
//  Status: set on qualified event when event_en[i]; intr_clr[i] clears; simultaneous set and clear -> set wins.
//  Counter: +1 per qualified, enabled event; saturates at 2^CNT_W-1 (no wrap); cleared only by reset.
//  Threshold/hyst/mode changes take effect on the next valid sample; no retroactive events.
//  thr=0: above stays 1 once armed. hyst>=thr: lo=0, so falling edges are impossible.
// TESTING  (N=4, DATA_W=10, PERSIST=2, CNT_W=2, hyst=10, ch0 thr=100, all en=1, mask=0)
//  1 arm: reset, first valid sample 150 -> above[0]=1 next cycle, event_pulse=0, intr_status=0.
//  2 hysteresis, ch0 mode 11: from 50, samples 105,105 -> rising pulse, status[0]=1.
//    Then 95,95 -> no fall (95>=90). Then 85,85 -> falling pulse.
//  3 persistence: alternating 50,105,50,105 -> no event, pcnt never reaches 2.
//    Then 105,invalid,105 -> event (invalid cycle holds count).
//  4 sticky: intr_clr[0] in the same cycle as a new event -> status stays 1. Clr alone -> 0.
//    event_mask[0]=1 with status=1 -> intr=0.
//  5 saturation: 4 rising/falling pairs on ch0 (mode 11) -> evt_cnt ch0 = 3, held.
//    Mode 00 on ch1 -> ch1 count stays 0.
//  6 reset mid-op: reset asserted with pcnt=1 -> all outputs 0.
//    Next valid sample 105 arms without an event.

Source files
------------

// File: rtl/adc_window_event_ctrl.sv
// rtl/adc_window_event_ctrl.sv - per-channel ADC threshold window with hysteresis, debounce, edge events
// Sticky W1C status, masked interrupt and saturating event counters on the ADC word clock.
module adc_window_event_ctrl #(
  parameter int N       = 10,
  parameter int DATA_W  = 10,
  parameter int PERSIST = 2,
  parameter int CNT_W   = 8
) (
  input  logic                  adc_wclk,
  input  logic                  adc_wclk_rst,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_valid,
  input  logic [N*DATA_W-1:0]   thr_bus,
  input  logic [DATA_W-1:0]     hyst,
  input  logic [2*N-1:0]        mode_bus,
  input  logic [N-1:0]          event_en,
  input  logic [N-1:0]          event_mask,
  input  logic [N-1:0]          intr_clr,
  output logic [N-1:0]          above,
  output logic [N-1:0]          event_pulse,
  output logic [N-1:0]          intr_status,
  output logic                  intr,
  output logic [N*CNT_W-1:0]    evt_cnt_bus
);

  localparam int PW = (PERSIST < 2) ? 1 : $clog2(PERSIST + 1);

  logic                 armed_q, armed_d;
  logic [N-1:0]         above_q, above_d;
  logic [N-1:0]         pulse_q, pulse_d;
  logic [N-1:0]         status_q, status_d;
  logic                 intr_q, intr_d;
  logic [N*CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]        pcnt_q [N];
  logic [PW-1:0]        pcnt_d [N];

  logic [DATA_W-1:0]    thr_w [N];
  logic [DATA_W-1:0]    lo_w  [N];
  logic [PW-1:0]        pcnt_inc [N];
  logic [N-1:0]         cand, fire, qual;

  for (genvar g = 0; g < N; g++) begin : g_ch
    assign thr_w[g]    = thr_bus[g*DATA_W +: DATA_W];
    assign lo_w[g]     = (thr_w[g] > hyst) ? (thr_w[g] - hyst) : '0;
    // Only the side of the window opposite the current level can produce a candidate.
    assign cand[g]     = above_q[g] ? (data_in < lo_w[g]) : (data_in >= thr_w[g]);
    assign pcnt_inc[g] = pcnt_q[g] + 1'b1;
    assign fire[g]     = armed_q & data_valid & cand[g] & (pcnt_inc[g] == PW'(PERSIST));
    assign qual[g]     = fire[g] & (above_q[g] ? mode_bus[2*g+1] : mode_bus[2*g]);
  end

  always_comb begin
    armed_d  = armed_q;
    above_d  = above_q;
    pcnt_d   = pcnt_q;
    pulse_d  = qual;
    status_d = (status_q & ~intr_clr) | (qual & event_en);
    cnt_d    = cnt_q;
    intr_d   = |(status_q & ~event_mask);
    if (data_valid) begin
      if (!armed_q) begin
        armed_d = 1'b1;
        for (int i = 0; i < N; i++) begin
          above_d[i] = (data_in >= thr_w[i]);
          pcnt_d[i]  = '0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (fire[i]) begin
            above_d[i] = ~above_q[i];
            pcnt_d[i]  = '0;
          end else if (cand[i]) begin
            pcnt_d[i]  = pcnt_inc[i];
          end else begin
            pcnt_d[i]  = '0;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (qual[i] && event_en[i] && (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
        cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + 1'b1;
    end
  end

  always_ff @(posedge adc_wclk) begin
    if (adc_wclk_rst) begin
      armed_q  <= 1'b0;
      above_q  <= '0;
      pulse_q  <= '0;
      status_q <= '0;
      intr_q   <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < N; i++) pcnt_q[i] <= '0;
    end else begin
      armed_q  <= armed_d;
      above_q  <= above_d;
      pulse_q  <= pulse_d;
      status_q <= status_d;
      intr_q   <= intr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < N; i++) pcnt_q[i] <= pcnt_d[i];
    end
  end

  assign above       = above_q;
  assign event_pulse = pulse_q;
  assign intr_status = status_q;
  assign intr        = intr_q;
  assign evt_cnt_bus = cnt_q;

endmodule

// File: tb/tb_adc_window_event_ctrl.sv
// tb/tb_adc_window_event_ctrl.sv - scoreboard bench for adc_window_event_ctrl
// Stimulus pushes expected events; a negedge monitor pops and compares each event_pulse.
module tb_adc_window_event_ctrl;

  localparam int N = 4, DW = 10, P = 2, CW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   data_in = '0;
  logic            data_valid = 1'b0;
  logic [N*DW-1:0] thr_bus = {10'd1000, 10'd1000, 10'd100, 10'd100};
  logic [DW-1:0]   hyst = 10'd10;
  logic [2*N-1:0]  mode_bus = {2'b00, 2'b00, 2'b00, 2'b11};
  logic [N-1:0]    event_en = 4'hF;
  logic [N-1:0]    event_mask = 4'h0;
  logic [N-1:0]    intr_clr = 4'h0;
  logic [N-1:0]    above, event_pulse, intr_status;
  logic            intr;
  logic [N*CW-1:0] evt_cnt_bus;

  adc_window_event_ctrl #(.N(N), .DATA_W(DW), .PERSIST(P), .CNT_W(CW)) dut (
    .adc_wclk(clk), .adc_wclk_rst(rst), .data_in(data_in), .data_valid(data_valid),
    .thr_bus(thr_bus), .hyst(hyst), .mode_bus(mode_bus), .event_en(event_en),
    .event_mask(event_mask), .intr_clr(intr_clr), .above(above),
    .event_pulse(event_pulse), .intr_status(intr_status), .intr(intr),
    .evt_cnt_bus(evt_cnt_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           t;
    logic [N-1:0] pulse;
    logic [N-1:0] abv;
    logic [N-1:0] status;
    logic [N*CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic step(input logic [DW-1:0] d, input logic v, input logic [N-1:0] clr);
    @(negedge clk);
    data_in = d; data_valid = v; intr_clr = clr;
  endtask

  task automatic idle();
    step(10'd0, 1'b0, 4'h0);
  endtask

  // Drives the sample that completes a persistence run and records the expected response.
  task automatic ev(input logic [DW-1:0] d, input logic [N-1:0] clr, input logic [N-1:0] abv,
                    input logic [N-1:0] status, input logic [N*CW-1:0] cnt);
    exp_t e;
    @(negedge clk);
    data_in = d; data_valid = 1'b1; intr_clr = clr;
    e.t = cyc + 1; e.pulse = 4'b0001; e.abv = abv; e.status = status; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    #1;
    check(name, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (event_pulse !== 4'h0) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {28'd0, event_pulse}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_cycle", cyc, e.t);
        check("pulse_vec", {28'd0, event_pulse}, {28'd0, e.pulse});
        check("evt_above", {28'd0, above}, {28'd0, e.abv});
        check("evt_status", {28'd0, intr_status}, {28'd0, e.status});
        check("evt_cnt", {24'd0, evt_cnt_bus}, {24'd0, e.cnt});
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_above", {28'd0, above}, 0);
    check("rst_pulse", {28'd0, event_pulse}, 0);
    check("rst_status", {28'd0, intr_status}, 0);
    check("rst_intr", {31'd0, intr}, 0);
    check("rst_cnt", {24'd0, evt_cnt_bus}, 0);
    rst = 1'b0;

    // arming
    step(10'd150, 1'b1, 4'h0);
    idle();
    check("arm_above", {28'd0, above}, 32'h3);
    check("arm_pulse", {28'd0, event_pulse}, 0);
    check("arm_status", {28'd0, intr_status}, 0);

    // hysteresis
    step(10'd50, 1'b1, 4'h0);
    ev(10'd50, 4'h0, 4'b0000, 4'b0001, 8'h01);
    idle(); idle();
    check("intr_set", {31'd0, intr}, 1);
    step(10'd0, 1'b0, 4'h1);
    idle();
    check("clr_status", {28'd0, intr_status}, 0);
    idle();
    check("clr_intr", {31'd0, intr}, 0);
    step(10'd105, 1'b1, 4'h0);
    ev(10'd105, 4'h0, 4'b0011, 4'b0001, 8'h02);
    step(10'd95, 1'b1, 4'h0);
    step(10'd95, 1'b1, 4'h0);
    idle();
    check("hyst_hold", {28'd0, above}, 32'h3);
    step(10'd85, 1'b1, 4'h0);
    ev(10'd85, 4'h0, 4'b0000, 4'b0001, 8'h03);
    step(10'd0, 1'b0, 4'h1);
    drain("drain_hyst");

    // persistence
    step(10'd50, 1'b1, 4'h0);
    step(10'd105, 1'b1, 4'h0);
    step(10'd50, 1'b1, 4'h0);
    step(10'd105, 1'b1, 4'h0);
    step(10'd50, 1'b1, 4'h0);
    idle();
    check("alt_above", {28'd0, above}, 0);
    check("alt_status", {28'd0, intr_status}, 0);
    step(10'd105, 1'b1, 4'h0);
    step(10'd50, 1'b0, 4'h0);
    ev(10'd105, 4'h0, 4'b0011, 4'b0001, 8'h03);
    drain("drain_persist");

    // sticky status and mask
    step(10'd85, 1'b1, 4'h0);
    ev(10'd85, 4'h1, 4'b0000, 4'b0001, 8'h03);
    idle();
    check("set_wins", {28'd0, intr_status}, 32'h1);
    step(10'd0, 1'b0, 4'h1);
    idle();
    check("clr_alone", {28'd0, intr_status}, 0);
    step(10'd105, 1'b1, 4'h0);
    ev(10'd105, 4'h0, 4'b0011, 4'b0001, 8'h03);
    idle(); idle();
    check("intr_unmasked", {31'd0, intr}, 1);
    event_mask = 4'h1;
    idle(); idle();
    check("intr_masked", {31'd0, intr}, 0);
    event_mask = 4'h0;

    // saturation, ch1 mode off
    step(10'd85, 1'b1, 4'h0);
    ev(10'd85, 4'h0, 4'b0000, 4'b0001, 8'h03);
    step(10'd105, 1'b1, 4'h0);
    ev(10'd105, 4'h0, 4'b0011, 4'b0001, 8'h03);
    idle();
    check("sat_cnt", {24'd0, evt_cnt_bus}, 32'h03);
    drain("drain_sat");

    // reset mid-persistence
    step(10'd85, 1'b1, 4'h0);
    @(negedge clk);
    rst = 1'b1; data_in = 10'd85; data_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; data_valid = 1'b0;
    check("mid_rst_above", {28'd0, above}, 0);
    check("mid_rst_status", {28'd0, intr_status}, 0);
    check("mid_rst_intr", {31'd0, intr}, 0);
    check("mid_rst_cnt", {24'd0, evt_cnt_bus}, 0);
    check("mid_rst_pulse", {28'd0, event_pulse}, 0);
    step(10'd105, 1'b1, 4'h0);
    idle();
    check("rearm_above", {28'd0, above}, 32'h3);
    step(10'd85, 1'b1, 4'h0);
    ev(10'd85, 4'h0, 4'b0000, 4'b0001, 8'h01);
    idle();
    drain("drain_final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
